tx_cic_interp_x3: RTL and testbench
===================================

Name: tx_cic_interp_x3

Overview:
- Transmit-side third-order CIC interpolator; the upsampling counterpart of the Rx comb decimation chain.
- Accepts low-rate signed samples over a valid/ready handshake and runs them through 3 comb stages at input rate.
- Zero-stuffs by R, then runs 3 integrator stages at clk rate.
- Emits exactly R high-rate samples per accepted input toward the Tx DAC/modulator path, with output backpressure.

Parameters:
- IN_W, 8: input sample width, signed.
- R, 8: interpolation factor; power of two, 2..16.
- R_LOG2, 3: log2(R); must match R.
- OUT_W, 17: output width; must be >= IN_W + 3*R_LOG2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  IN_W  signed low-rate sample
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept in_data this cycle
- out_data  out  OUT_W  signed interpolated sample, registered
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream consumes out_data this cycle

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset: in_ready=1, out_valid=0, out_data=0. Comb delay registers, integrators, phase counter and busy flag all 0. Reset mid-burst discards the burst; no partial output after release.
- Arithmetic: all comb/integrator registers are OUT_W wide and two's-complement, wrapping (no saturation). in_data is sign-extended to OUT_W. Output is exact whenever the true result fits OUT_W.
- Accept: fires when in_valid && in_ready.
- Comb update on accept (registered):
  - c1 = x - x_d
  - c2 = c1 - c1_d
  - c3 = c2 - c2_d
  - Delay registers update with the new values. Comb output held in register u_hold.
- State: busy flag (IDLE when 0, RUN when 1) plus phase counter 0..R-1.
- Accept in IDLE: busy<=1, phase<=0.
- Beat: occurs when busy && (!out_valid || out_ready).
- On each beat:
  - u = u_hold if phase==0, else 0
  - i1' = i1+u
  - i2' = i2+i1'
  - i3' = i3+i2'
  - out_data<=i3', out_valid<=1
  - phase<=phase+1, wrapping at R-1
- in_ready = !busy || (phase==R-1 && beat), so back-to-back inputs sustain one input per R cycles with no bubble.
- Last-phase beat with no accept: busy<=0.
- out_valid clears when out_ready && !beat.
- out_ready low: no beat; out_data and out_valid held stable; phase, integrators and in_ready frozen.
- Latency: accept at edge E0; first beat at E1; out_valid high after E1. Outputs 2..R follow on consecutive edges while out_ready=1.
- Input underflow (in_valid low at the last phase): integrators and comb state retained; the stream resumes seamlessly on the next accept, and the gap inserts no samples.
- DC gain is R^2 (64 at default).

Optional Feature:
- Macro: CIC_GAIN_COMP_EN.
- Defined: out_data = (i3' + 2^(2*R_LOG2-1)) >>> (2*R_LOG2), an arithmetic shift with round-half-up, sign-extended to OUT_W. Net DC gain 1; latency unchanged.
- Undefined: raw i3' output with DC gain R^2.

Test Plan:
- Reset then idle: in_valid=0 for 20 cycles -> out_valid=0, in_ready=1, out_data=0. Async assert of rst_n mid-burst -> all outputs return to reset values immediately.
- Impulse, R=8, out_ready=1: in_data 1 then 0,0,0 -> first 8 outputs 1,3,6,10,15,21,28,36.
  - Full response is 22 nonzero samples summing to 512, then zeros.
  - out_valid goes high 1 cycle after the accept edge.
- DC: constant 1 streamed back-to-back -> in_ready pulses once per 8 cycles, no bubbles in out_valid, steady-state out_data=64.
  - Constant -128 -> steady -8192.
  - With CIC_GAIN_COMP_EN: steady 1 and -128 respectively.
- Backpressure: random out_ready at 50% during impulse -> identical output sequence to the out_ready=1 case.
  - out_data stable while out_valid && !out_ready.
  - Exactly 8 outputs per accepted input.
- Underflow: 3 samples, a 20-cycle in_valid gap, then 3 samples -> output sequence equals the gapless stream's with idle cycles inserted only; no extra or dropped samples.
- Wrap: alternating +127/-128 inputs -> outputs match a bit-true model; intermediate wrap in integrators does not corrupt final values.

Source files
------------

// File: rtl/tx_cic_interp_x3.sv
// Third-order CIC interpolator (x R): comb stages at input rate, zero-stuff, integrators at clk rate.
// Optional macro CIC_GAIN_COMP_EN rounds out the R^2 DC gain (arithmetic shift, round-half-up).
module tx_cic_interp_x3 #(
   parameter int IN_W   = 8,
   parameter int R      = 8,
   parameter int R_LOG2 = 3,
   parameter int OUT_W  = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   localparam logic [R_LOG2-1:0] PH_LAST = R_LOG2'(R - 1);

   state_e                   state_q, state_d;
   logic [R_LOG2-1:0]        phase_q, phase_d;
   logic signed [OUT_W-1:0]  x_d_q, c1_d_q, c2_d_q, u_hold_q;
   logic signed [OUT_W-1:0]  i1_q, i2_q, i3_q;
   logic [OUT_W-1:0]         out_data_q, out_data_d;
   logic                     out_valid_q, out_valid_d;

   logic                     beat, last, accept;
   logic signed [OUT_W-1:0]  x_ext, c1, c2, c3, u, i1_n, i2_n, i3_n, out_n;

   assign x_ext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
   assign c1    = x_ext - x_d_q;
   assign c2    = c1 - c1_d_q;
   assign c3    = c2 - c2_d_q;

   // Zero-stuffing: only phase 0 of each burst carries the comb output.
   assign u    = (phase_q == '0) ? u_hold_q : '0;
   assign i1_n = i1_q + u;
   assign i2_n = i2_q + i1_n;
   assign i3_n = i3_q + i2_n;

`ifdef CIC_GAIN_COMP_EN
   localparam int SH = 2 * R_LOG2;
   logic signed [OUT_W-1:0] rnd;
   assign rnd   = i3_n + $signed(OUT_W'(1) << (SH - 1));
   assign out_n = rnd >>> SH;
`else
   assign out_n = i3_n;
`endif

   assign beat     = (state_q == RUN) && (!out_valid_q || out_ready);
   assign last     = (phase_q == PH_LAST);
   assign in_ready = (state_q == IDLE) || (last && beat);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (beat) begin
         phase_d     = phase_q + 1'b1;   // R is a power of two: wraps at R-1
         out_valid_d = 1'b1;
         out_data_d  = out_n;
         if (last && !accept) state_d = IDLE;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (accept) begin
         state_d = RUN;
         if (state_q == IDLE) phase_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_d_q    <= '0;
         c1_d_q   <= '0;
         c2_d_q   <= '0;
         u_hold_q <= '0;
         i1_q     <= '0;
         i2_q     <= '0;
         i3_q     <= '0;
      end else begin
         if (accept) begin
            x_d_q    <= x_ext;
            c1_d_q   <= c1;
            c2_d_q   <= c2;
            u_hold_q <= c3;
         end
         if (beat) begin
            i1_q <= i1_n;
            i2_q <= i2_n;
            i3_q <= i3_n;
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_tx_cic_interp_x3.sv
// Directed bench for tx_cic_interp_x3: impulse, DC, backpressure, underflow, wrap and reset cases.
module tb_tx_cic_interp_x3;
   localparam int IN_W = 8, R = 8, R_LOG2 = 3, OUT_W = 17;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [IN_W-1:0]  in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready = 1'b1;

   tx_cic_interp_x3 #(.IN_W(IN_W), .R(R), .R_LOG2(R_LOG2), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   logic bp_en = 1'b0;
   int cap_q[$], cyc_q[$], acc_q[$];
   logic signed [OUT_W-1:0] prev_data = '0;
   logic prev_stall = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Output monitor: picks out_ready each cycle, logs transfers, checks hold under stall.
   always @(negedge clk) begin
      cyc++;
      out_ready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (rst_n) begin
         if (prev_stall) chk("hold", int'($signed(out_data)), int'(prev_data));
         if (out_valid && out_ready) begin
            cap_q.push_back(int'($signed(out_data)));
            cyc_q.push_back(cyc);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = $signed(out_data);
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Bit-true reference: comb at input rate, R-fold zero-stuff, triple integrate, OUT_W wrap.
   task automatic model(input int xs[$], output int ys[$]);
      logic signed [OUT_W-1:0] xe, xd, c1, c1d, c2, c2d, c3, u, i1, i2, i3, t;
      xd = '0; c1d = '0; c2d = '0; i1 = '0; i2 = '0; i3 = '0;
      ys = {};
      foreach (xs[k]) begin
         xe = OUT_W'(xs[k]);
         c1 = xe - xd;  xd  = xe;
         c2 = c1 - c1d; c1d = c1;
         c3 = c2 - c2d; c2d = c2;
         for (int p = 0; p < R; p++) begin
            u  = (p == 0) ? c3 : '0;
            i1 = i1 + u;
            i2 = i2 + i1;
            i3 = i3 + i2;
`ifdef CIC_GAIN_COMP_EN
            t = i3 + OUT_W'(32);
            t = t >>> 6;
`else
            t = i3;
`endif
            ys.push_back(int'(t));
         end
      end
   endtask

   task automatic send(input int x);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = x[IN_W-1:0];
      for (int t = 0; t < 400; t++) begin
         #2;
         if (in_ready) begin
            acc_q.push_back(cyc);
            @(posedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      #1 in_valid = 1'b0;
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic stream(input int xs[$]);
      foreach (xs[k]) send(xs[k]);
   endtask

   task automatic wait_out(input string tag, input int n);
      for (int t = 0; t < 3000; t++) begin
         if (cap_q.size() >= n) break;
         @(negedge clk);
      end
      repeat (30) @(negedge clk);
      chk(tag, cap_q.size(), n);
   endtask

   task automatic cmp_stream(input string tag, input int xs[$]);
      int ys[$];
      model(xs, ys);
      for (int i = 0; i < ys.size() && i < cap_q.size(); i++) chk(tag, cap_q[i], ys[i]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      cap_q = {}; cyc_q = {}; acc_q = {};
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   int imp8[8];
   int xs[$];
   int sum, nz;

   initial begin
`ifdef CIC_GAIN_COMP_EN
      imp8 = '{0, 0, 0, 0, 0, 0, 0, 1};
`else
      imp8 = '{1, 3, 6, 10, 15, 21, 28, 36};
`endif
      // Reset and idle
      do_reset();
      repeat (20) @(negedge clk);
      #2;
      chk("idle_valid", int'(out_valid), 0);
      chk("idle_ready", int'(in_ready), 1);
      chk("idle_data", int'(out_data), 0);
      chk("idle_cnt", cap_q.size(), 0);

      // Impulse with out_ready=1
      xs = '{1, 0, 0, 0};
      stream(xs);
      wait_out("imp_count", 32);
      for (int i = 0; i < 8; i++) chk($sformatf("imp_first[%0d]", i), cap_q[i], imp8[i]);
      chk("imp_latency", cyc_q[0] - acc_q[0], 2);
`ifndef CIC_GAIN_COMP_EN
      sum = 0; nz = 0;
      foreach (cap_q[i]) begin sum += cap_q[i]; if (cap_q[i] != 0) nz++; end
      chk("imp_sum", sum, 512);
      chk("imp_nonzero", nz, 22);
`endif
      cmp_stream("imp_model", xs);

      // DC +1 back-to-back
      do_reset();
      xs = {};
      for (int i = 0; i < 10; i++) xs.push_back(1);
      stream(xs);
      wait_out("dc1_count", 80);
      chk("dc1_accept_spacing", acc_q[9] - acc_q[0], 72);
      chk("dc1_no_bubble", cyc_q[79] - cyc_q[0], 79);
`ifdef CIC_GAIN_COMP_EN
      chk("dc1_steady", cap_q[79], 1);
`else
      chk("dc1_steady", cap_q[79], 64);
`endif
      cmp_stream("dc1_model", xs);

      // DC -128
      do_reset();
      xs = {};
      for (int i = 0; i < 6; i++) xs.push_back(-128);
      stream(xs);
      wait_out("dcn_count", 48);
`ifdef CIC_GAIN_COMP_EN
      chk("dcn_steady", cap_q[47], -128);
`else
      chk("dcn_steady", cap_q[47], -8192);
`endif

      // Impulse under random backpressure
      do_reset();
      bp_en = 1'b1;
      xs = '{1, 0, 0, 0};
      stream(xs);
      wait_out("bp_count", 32);
      bp_en = 1'b0;
      for (int i = 0; i < 8; i++) chk($sformatf("bp_first[%0d]", i), cap_q[i], imp8[i]);
      cmp_stream("bp_model", xs);

      // Underflow: 20-cycle gap in the input stream
      do_reset();
      xs = '{5, -3, 7};
      stream(xs);
      repeat (20) @(negedge clk);
      xs = '{2, 9, -4};
      stream(xs);
      wait_out("uf_count", 48);
      xs = '{5, -3, 7, 2, 9, -4};
      cmp_stream("uf_model", xs);

      // Alternating full-scale inputs exercise integrator wrap
      do_reset();
      xs = {};
      for (int i = 0; i < 8; i++) xs.push_back((i % 2 == 0) ? 127 : -128);
      stream(xs);
      wait_out("wrap_count", 64);
      cmp_stream("wrap_model", xs);

      // Asynchronous reset mid-burst
      do_reset();
      send(3);
      repeat (3) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_valid", int'(out_valid), 0);
      chk("arst_ready", int'(in_ready), 1);
      chk("arst_data", int'(out_data), 0);
      @(negedge clk);
      #2;
      cap_q = {};
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("arst_no_output", cap_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
